instr_fetch_unit: RTL and testbench

//  Instruction source for the single-cycle control/datapath pair: holds the PC and

---
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, req/ack imem fetch, valid/stall handshake, branch redirect on retire.
// Optional fetch timeout with sticky error is enabled by defining IFU_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [10:0]       func,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

`ifdef IFU_TIMEOUT_EN
  typedef enum logic [1:0] {START, FETCH, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {START, FETCH, HOLD} state_t;
`endif

  state_t state, state_nxt;
  logic   retire;
  logic   got_ack;

  // An ack only counts while a request is outstanding.
  assign got_ack = (state == FETCH) && imem_ack;

`ifdef IFU_TIMEOUT_EN
  localparam int CTR_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [CTR_W-1:0] to_ctr;
  logic             to_hit;

  assign to_hit = (state == FETCH) && !imem_ack && (to_ctr == CTR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_ctr    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == FETCH && !imem_ack && !to_hit) to_ctr <= to_ctr + 1'b1;
      else                                        to_ctr <= '0;
      if (to_hit) fetch_err <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= START;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    retire    = 1'b0;
    unique case (state)
      START: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = HOLD;
`ifdef IFU_TIMEOUT_EN
        else if (to_hit) state_nxt = ERR;
`endif
      end
      HOLD: begin
        if (instr_valid && !stall) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
`ifdef IFU_TIMEOUT_EN
      ERR: state_nxt = ERR;
`endif
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (got_ack) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      // Branch inputs are only meaningful on the retiring cycle.
      if (retire) begin
        pc          <= branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : pc + ADDR_W'(4);
        instr_valid <= 1'b0;
      end
    end
  end

  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target[1:0];

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign func      = instr[10:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized transaction-level check of instr_fetch_unit against a PC/instruction reference model.
module tb_instr_fetch_unit;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n, imem_req, imem_ack, stall, branch_taken;
  logic        instr_valid, fetch_err;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc;
  logic [5:0]  opcode;
  logic [10:0] func;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc, exp_instr;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .func(func),
    .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reset with ack held high throughout; a stale ack must not be captured.
  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom; stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_err", fetch_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    exp_pc = RST_PC;
    chk("start_vld", instr_valid, 0);
    chk("start_req", imem_req, 1);
    chk("start_addr", imem_addr, exp_pc);
  endtask

  task automatic fetch_one(input logic [31:0] data, input int lat);
    chk("f_req", imem_req, 1);
    chk("f_addr", imem_addr, exp_pc);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("f_wait_req", imem_req, 1);
      chk("f_wait_addr", imem_addr, exp_pc);
      chk("f_wait_vld", instr_valid, 0);
    end
    imem_ack = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    exp_instr = data;
    chk("f_vld", instr_valid, 1);
    chk("f_instr", instr, exp_instr);
    chk("f_opcode", 32'(opcode), 32'(exp_instr >> 26));
    chk("f_func", 32'(func), exp_instr % 2048);
    chk("f_pc", pc, exp_pc);
    chk("f_req_drop", imem_req, 0);
  endtask

  // Stalled cycles carry a live branch and spurious acks; neither may take effect.
  task automatic retire(input int stall_cyc, input logic bt, input logic [31:0] tgt);
    for (int i = 0; i < stall_cyc; i++) begin
      stall = 1'b1; branch_taken = 1'b1; branch_target = $urandom;
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      chk("h_vld", instr_valid, 1);
      chk("h_instr", instr, exp_instr);
      chk("h_pc", pc, exp_pc);
      chk("h_req", imem_req, 0);
    end
    stall = 1'b0; branch_taken = bt; branch_target = tgt; imem_ack = 1'b0;
    @(negedge clk);
    branch_taken = 1'b0; branch_target = $urandom;
    exp_pc = bt ? (tgt / 4) * 4 : exp_pc + 32'd4;
    chk("r_vld", instr_valid, 0);
    chk("r_req", imem_req, 1);
    chk("r_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    exp_pc = RST_PC; exp_instr = '0;
    @(negedge clk);
    do_reset();

    fetch_one(32'h8C22_07FF, 0);
    retire(0, 1'b0, 32'h0);
    fetch_one($urandom, 1);
    retire(1, 1'b0, 32'h0);
    fetch_one($urandom, 0);
    chk("seq_pc", pc, 32'h108);
    retire(0, 1'b1, 32'h203);
    chk("br_addr", imem_addr, 32'h200);
    fetch_one($urandom, 2);
    retire(10, 1'b0, 32'h0);
    chk("stall_rel_addr", imem_addr, 32'h204);

    // Reset mid-FETCH with ack asserted in the same and following cycles.
    do_reset();

    // Wrap from the top aligned word to zero.
    fetch_one($urandom, 0);
    retire(0, 1'b1, 32'hFFFF_FFFF);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_one($urandom, 1);
    retire(0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    for (int t = 0; t < 40; t++) begin
      fetch_one($urandom, int'($urandom_range(0, 3)));
      retire(int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), $urandom);
    end
    chk("rand_err", fetch_err, 0);

    do_reset();
`ifdef IFU_TIMEOUT_EN
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("to_err_early", fetch_err, 0);
    chk("to_req_early", imem_req, 1);
    @(negedge clk);
    chk("to_err", fetch_err, 1);
    chk("to_req", imem_req, 0);
    imem_ack = 1'b1; imem_rdata = $urandom;
    for (int i = 0; i < 5; i++) @(negedge clk);
    imem_ack = 1'b0;
    chk("to_err_sticky", fetch_err, 1);
    chk("to_park_req", imem_req, 0);
    chk("to_park_vld", instr_valid, 0);
    do_reset();
    chk("to_err_clr", fetch_err, 0);
`else
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("noto_err", fetch_err, 0);
    chk("noto_req", imem_req, 1);
    chk("noto_addr", imem_addr, RST_PC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
